bcd_down_counter: RTL and testbench

Multi-digit BCD countdown timer. It is the count-down counterpart of the team's 0–9 BCD up counter and feeds the same 7-segment display path. It is loaded with a BCD value, started, paused, and decremented once per qualified tick. When it reaches 00 it stops and signals completion. Digits are chained through borrow, so each digit wraps 0 -> 9 on borrow.

---
 rtl/bcd_pkg.sv | 19 +
 rtl/bcd_digit_dec.sv | 25 ++
 rtl/bcd_down_counter.sv | 127 ++++++++++++
 tb/tb_bcd_down_counter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD countdown timer: digit width, FSM states and
// the per-digit load clamp.
package bcd_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic logic [BCD_W-1:0] clamp_digit(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One combinational BCD digit of the decrement chain: with a borrow in, the
// digit steps down, wrapping 0 -> 9 and passing the borrow on.
module bcd_digit_dec
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] digit_in,
  input  logic             borrow_in,
  output logic [BCD_W-1:0] digit_out,
  output logic             borrow_out
);

  always_comb begin
    digit_out  = digit_in;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit_in == '0) begin
        digit_out  = BCD_MAX;
        borrow_out = 1'b1;
      end else begin
        digit_out = digit_in - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_down_counter.sv
// Multi-digit BCD countdown timer with load/start/pause control and a
// completion flag. Define BCD_DOWN_AUTO_RELOAD_EN to reload from the last
// loaded value instead of stopping at zero.
module bcd_down_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  tick,
  output logic [4*DIGITS-1:0]   out,
  output logic                  busy,
  output logic                  done,
  output logic                  done_pulse
);

  localparam int W = 4 * DIGITS;

  state_t         state_reg, state_next;
  logic [W-1:0]   out_reg, out_next;
  logic           pulse_reg, pulse_next;
  logic [W-1:0]   dec_val;
  logic [W-1:0]   load_clamped;
  logic [DIGITS:0] borrow;
  logic           is_zero;
  logic           is_one;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
  logic [W-1:0]   reload_reg, reload_next;
`endif

  // Borrow ripples out of the top digit only when every digit was zero.
  assign borrow[0] = 1'b1;
  assign is_zero   = borrow[DIGITS];
  assign is_one    = (out_reg == W'(1));

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_digit_dec u_dec (
        .digit_in   (out_reg[4*gi +: 4]),
        .borrow_in  (borrow[gi]),
        .digit_out  (dec_val[4*gi +: 4]),
        .borrow_out (borrow[gi+1])
      );
      assign load_clamped[4*gi +: 4] = clamp_digit(load_val[4*gi +: 4]);
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    out_next   = out_reg;
    pulse_next = 1'b0;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
    reload_next = reload_reg;
`endif
    if (load) begin
      out_next   = load_clamped;
      state_next = ST_IDLE;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
      reload_next = load_clamped;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) state_next = is_zero ? ST_DONE : ST_RUN;
        end
        ST_RUN: begin
          if (pause) begin
            state_next = ST_PAUSE;
          end else if (tick) begin
`ifdef BCD_DOWN_AUTO_RELOAD_EN
            // Zero is held for one tick so the completion pulse is visible
            // before the count restarts.
            if (is_zero) begin
              if (reload_reg == '0) state_next = ST_DONE;
              else                  out_next   = reload_reg;
            end else begin
              out_next   = dec_val;
              pulse_next = is_one;
            end
`else
            out_next = dec_val;
            if (is_one) begin
              pulse_next = 1'b1;
              state_next = ST_DONE;
            end
`endif
          end
        end
        ST_PAUSE: begin
          if (start && !pause) state_next = ST_RUN;
        end
        default: begin
          out_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      out_reg   <= '0;
      pulse_reg <= 1'b0;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
      reload_reg <= '0;
`endif
    end else begin
      state_reg <= state_next;
      out_reg   <= out_next;
      pulse_reg <= pulse_next;
`ifdef BCD_DOWN_AUTO_RELOAD_EN
      reload_reg <= reload_next;
`endif
    end
  end

  assign out        = out_reg;
  assign busy       = (state_reg == ST_RUN);
  assign done       = (state_reg == ST_DONE);
  assign done_pulse = pulse_reg;

endmodule

// File: tb/tb_bcd_down_counter.sv
// Scoreboard bench for bcd_down_counter: a decimal reference model queues the
// expected outputs per edge and a negedge monitor compares them.
module tb_bcd_down_counter;

  localparam int DIGITS = 2;
  localparam int W = 4 * DIGITS;

  typedef struct packed {
    logic [W-1:0] out;
    logic         busy;
    logic         done;
    logic         pulse;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         start = 1'b0;
  logic         pause = 1'b0;
  logic         tick = 1'b0;
  logic [W-1:0] out;
  logic         busy, done, done_pulse;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Reference model: decimal count and a symbolic state (0 idle, 1 run, 2 pause, 3 done)
  int m_cnt = 0;
  int m_rld = 0;
  int m_st  = 0;
  bit m_pulse = 0;

  always #5 clk = ~clk;

  bcd_down_counter #(.DIGITS(DIGITS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_val   (load_val),
    .start      (start),
    .pause      (pause),
    .tick       (tick),
    .out        (out),
    .busy       (busy),
    .done       (done),
    .done_pulse (done_pulse)
  );

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int clamp_to_int(input logic [W-1:0] v);
    int r, p, d;
    r = 0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      d = int'(v[4*i +: 4]);
      if (d > 9) d = 9;
      r = r + d * p;
      p = p * 10;
    end
    return r;
  endfunction

  task automatic model_step(input bit r, l, input logic [W-1:0] v, input bit s, p, t);
    m_pulse = 0;
    if (!r) begin
      m_st = 0; m_cnt = 0; m_rld = 0;
    end else if (l) begin
      m_cnt = clamp_to_int(v); m_rld = m_cnt; m_st = 0;
    end else begin
      case (m_st)
        0: if (s) m_st = (m_cnt == 0) ? 3 : 1;
        1: begin
          if (p) m_st = 2;
          else if (t) begin
`ifdef BCD_DOWN_AUTO_RELOAD_EN
            if (m_cnt == 0) begin
              if (m_rld == 0) m_st = 3;
              else            m_cnt = m_rld;
            end else begin
              m_cnt = m_cnt - 1;
              if (m_cnt == 0) m_pulse = 1;
            end
`else
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
              m_pulse = 1;
              m_st = 3;
            end
`endif
          end
        end
        2: if (s && !p) m_st = 1;
        default: ;
      endcase
    end
  endtask

  task automatic step(input bit r, l, input logic [W-1:0] v, input bit s, p, t);
    exp_t e;
    rst_n = r; load = l; load_val = v; start = s; pause = p; tick = t;
    @(posedge clk);
    model_step(r, l, v, s, p, t);
    e.out = to_bcd(m_cnt);
    e.busy = (m_st == 1);
    e.done = (m_st == 3);
    e.pulse = m_pulse;
    exp_q.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({out, busy, done, done_pulse} !== e) begin
        n_fail++;
        $display("FAIL outputs @%0t: got out=%h busy=%b done=%b pulse=%b, expected out=%h busy=%b done=%b pulse=%b",
                 $time, out, busy, done, done_pulse, e.out, e.busy, e.done, e.pulse);
      end else begin
        $display("check @%0t: out=%h busy=%b done=%b pulse=%b", $time, out, busy, done, done_pulse);
      end
    end
  end

  initial begin
    // Reset dominates load and tick
    step(0, 1, 8'h55, 0, 0, 1);
    step(0, 1, 8'h55, 0, 0, 1);
    // Clamp 3C -> 39 and full countdown
    step(1, 1, 8'h3C, 0, 0, 0);
    step(1, 0, 8'h00, 1, 0, 0);
    repeat (39) step(1, 0, 8'h00, 0, 0, 1);
    repeat (3) step(1, 0, 8'h00, 1, 1, 1);
    // Borrow across digits, then start from zero
    step(1, 1, 8'h10, 0, 0, 0);
    step(1, 0, 8'h00, 1, 0, 0);
    step(1, 0, 8'h00, 0, 0, 1);
    step(1, 1, 8'h00, 0, 0, 0);
    step(1, 0, 8'h00, 1, 0, 1);
    step(1, 0, 8'h00, 0, 0, 1);
    // Pause and resume
    step(1, 1, 8'h05, 0, 0, 0);
    step(1, 0, 8'h00, 1, 0, 0);
    repeat (2) step(1, 0, 8'h00, 0, 0, 1);
    repeat (5) step(1, 0, 8'h00, 0, 1, 1);
    step(1, 0, 8'h00, 1, 1, 1);
    step(1, 0, 8'h00, 1, 0, 0);
    repeat (4) step(1, 0, 8'h00, 0, 0, 1);
    // Load mid-run, ticks ignored in IDLE
    step(1, 1, 8'h20, 0, 0, 0);
    step(1, 0, 8'h00, 1, 0, 0);
    repeat (3) step(1, 0, 8'h00, 0, 0, 1);
    step(1, 1, 8'h42, 0, 0, 1);
    repeat (3) step(1, 0, 8'h00, 0, 0, 1);
    step(1, 0, 8'h00, 1, 0, 0);
    step(1, 0, 8'h00, 0, 0, 1);
    // Terminal behaviour (one-shot or auto-reload depending on build)
    step(1, 1, 8'h02, 0, 0, 0);
    step(1, 0, 8'h00, 1, 0, 0);
    repeat (6) step(1, 0, 8'h00, 0, 0, 1);
    // Reset mid-count
    step(0, 0, 8'h00, 0, 0, 1);
    step(1, 0, 8'h00, 1, 0, 1);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(99) != 0), ($urandom_range(19) == 0), W'($urandom),
           ($urandom_range(9) == 0), ($urandom_range(9) == 0), ($urandom_range(9) < 6));
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
